// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op encodings (identical to the ALU s select)
// and the sequencer state enumeration.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SHIFT = 2'b01,
        OP_COUNT = 2'b10,
        OP_AND   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_EXEC,
        ST_RUN,
        ST_CAPTURE,
        ST_RESP
    } state_e;

    // SHIFT and COUNT are the only ops that use the ALU's stored state.
    function automatic logic op_is_sequential(input op_e op);
        return (op == OP_SHIFT) || (op == OP_COUNT);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command-driven controller that drives one shared 8-bit ALU for a single requester
// and returns the captured ALU result over a valid/ready response channel.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_a,
    input  logic [7:0]    cmd_b,
    input  logic          cmd_cin,
    input  logic          cmd_clr,
    input  logic [CW-1:0] cmd_count,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic          rsp_cout,
    output logic          busy,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic          alu_L,
    output logic          alu_En,
    output logic [1:0]    alu_s,
    output logic          alu_reset,
    input  logic [7:0]    alu_f,
    input  logic          alu_cout
);

    state_e        state, next_state;
    op_e           lat_op;
    logic [7:0]    lat_a, lat_b;
    logic          lat_cin;
    logic [CW-1:0] lat_count, run_cnt;

    logic          accept;
    op_e           cur_op;
    logic [7:0]    cur_a, cur_b;
    logic          cur_cin;
    logic [CW-1:0] cur_count;

    logic [7:0]    nxt_alu_a, nxt_alu_b;
    logic [1:0]    nxt_alu_s;
    logic          nxt_alu_L, nxt_alu_En;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign alu_reset = reset || (state == ST_CLEAR);

    // In IDLE the command being accepted is still on the inputs; afterwards the latched copy is used.
    assign cur_op    = (state == ST_IDLE) ? op_e'(cmd_op) : lat_op;
    assign cur_a     = (state == ST_IDLE) ? cmd_a         : lat_a;
    assign cur_b     = (state == ST_IDLE) ? cmd_b         : lat_b;
    assign cur_cin   = (state == ST_IDLE) ? cmd_cin       : lat_cin;
    assign cur_count = (state == ST_IDLE) ? cmd_count     : lat_count;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_clr && op_is_sequential(cur_op)) begin
                        next_state = ST_CLEAR;
                    end else begin
                        case (cur_op)
                            OP_COUNT: next_state = ST_LOAD;
                            OP_SHIFT: next_state = (cur_count != '0) ? ST_RUN : ST_CAPTURE;
                            default:  next_state = ST_EXEC;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                if (cur_op == OP_COUNT) begin
                    next_state = ST_LOAD;
                end else begin
                    next_state = (cur_count != '0) ? ST_RUN : ST_CAPTURE;
                end
            end
            ST_LOAD:    next_state = (cur_count != '0) ? ST_RUN : ST_CAPTURE;
            ST_EXEC:    next_state = ST_RESP;
            ST_RUN:     next_state = (run_cnt == CW'(1)) ? ST_CAPTURE : ST_RUN;
            ST_CAPTURE: next_state = ST_RESP;
            ST_RESP:    next_state = rsp_ready ? ST_IDLE : ST_RESP;
            default:    next_state = ST_IDLE;
        endcase
    end

    // NOTE: ALU controls are computed for next_state and registered, so they are valid for the whole state.
    always_comb begin
        nxt_alu_a  = alu_a;
        nxt_alu_b  = alu_b;
        nxt_alu_s  = alu_s;
        nxt_alu_L  = 1'b0;
        nxt_alu_En = 1'b0;
        case (next_state)
            ST_CLEAR: begin
                nxt_alu_s = cur_op;
                nxt_alu_a = cur_a;
                nxt_alu_b = cur_b;
            end
            ST_LOAD: begin
                nxt_alu_s  = OP_COUNT;
                nxt_alu_a  = cur_a;
                nxt_alu_L  = 1'b1;
                nxt_alu_En = 1'b1;
            end
            ST_EXEC: begin
                nxt_alu_s = cur_op;
                nxt_alu_a = cur_a;
                nxt_alu_b = cur_b;
                nxt_alu_L = (cur_op == OP_ADD) ? cur_cin : 1'b0;
            end
            ST_RUN: begin
                nxt_alu_s  = cur_op;
                nxt_alu_a  = cur_a;
                nxt_alu_En = (cur_op == OP_COUNT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: synchronous reset clears every register, including the latched command, so an abort leaves nothing pending.
        if (reset) begin
            state     <= ST_IDLE;
            lat_op    <= OP_ADD;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_cin   <= 1'b0;
            lat_count <= '0;
            run_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            alu_L     <= 1'b0;
            alu_En    <= 1'b0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != ST_IDLE);
            rsp_valid <= (next_state == ST_RESP);
            alu_a     <= nxt_alu_a;
            alu_b     <= nxt_alu_b;
            alu_s     <= nxt_alu_s;
            alu_L     <= nxt_alu_L;
            alu_En    <= nxt_alu_En;

            if (accept) begin
                lat_op    <= cur_op;
                lat_a     <= cmd_a;
                lat_b     <= cmd_b;
                lat_cin   <= cmd_cin;
                lat_count <= cmd_count;
            end

            // Run length reloads on entry to RUN and counts down to the exit at 1.
            if (state == ST_RUN) begin
                run_cnt <= run_cnt - CW'(1);
            end else if (next_state == ST_RUN) begin
                run_cnt <= cur_count;
            end

            if (state == ST_EXEC) begin
                rsp_data <= alu_f;
                rsp_cout <= (lat_op == OP_ADD) ? alu_cout : 1'b0;
            end else if (state == ST_CAPTURE) begin
                rsp_data <= alu_f;
                rsp_cout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: a behavioural model of the shared ALU sits beside alu_sequencer,
// and a scoreboard queue of expected responses is checked as each response appears.
module tb_alu_sequencer;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_a, cmd_b;
    logic          cmd_cin, cmd_clr;
    logic [CW-1:0] cmd_count;
    logic          rsp_valid, rsp_ready;
    logic [7:0]    rsp_data;
    logic          rsp_cout, busy;
    logic [7:0]    alu_a, alu_b, alu_f;
    logic          alu_L, alu_En, alu_reset, alu_cout;
    logic [1:0]    alu_s;

    typedef struct {
        logic [7:0] data;
        logic       cout;
        int         lat;
        int         clr_used;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    alu_sequencer #(.CW(CW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_clr(cmd_clr), .cmd_count(cmd_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
        .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_L(alu_L), .alu_En(alu_En),
        .alu_s(alu_s), .alu_reset(alu_reset), .alu_f(alu_f), .alu_cout(alu_cout)
    );

    // ALU model: shift register takes alu_a[0] in at the LSB every clock while s selects SHIFT.
    logic [7:0] alu_sr, alu_cnt;
    logic [8:0] alu_sum;

    always_ff @(posedge clock) begin
        if (alu_reset) begin
            alu_sr  <= '0;
            alu_cnt <= '0;
        end else begin
            if (alu_s == 2'b01) alu_sr <= {alu_sr[6:0], alu_a[0]};
            if (alu_s == 2'b10 && alu_En) alu_cnt <= alu_L ? alu_a : alu_cnt + 8'd1;
        end
    end

    always_comb begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_L};
        alu_cout = (alu_s == 2'b00) ? alu_sum[8] : 1'b0;
        case (alu_s)
            2'b00:   alu_f = alu_sum[7:0];
            2'b01:   alu_f = alu_sr;
            2'b10:   alu_f = alu_cnt;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic clr, input int n);
        exp_t e;
        logic [8:0] s9;
        int clr_used;
        clr_used = (clr && (op == 2'b01 || op == 2'b10)) ? 1 : 0;
        e.cout = 1'b0;
        e.clr_used = clr_used;
        case (op)
            2'b00: begin
                s9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                e.data = s9[7:0];
                e.cout = s9[8];
                e.lat  = 2;
            end
            2'b11: begin
                e.data = a & b;
                e.lat  = 2;
            end
            2'b01: begin
                // Only used after a clear: n ones shifted into a zeroed register when a[0]=1.
                e.data = !a[0] ? 8'h00 : (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
                e.lat  = n + 2 + clr_used;
            end
            default: begin
                e.data = 8'(a + n);
                e.lat  = n + 3 + clr_used;
            end
        endcase
        return e;
    endfunction

    // Drive one command, wait for the response, compare against the scoreboard head.
    // During 'hold' backpressure cycles a second command is presented and must not be taken.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic clr, input int n, input int hold);
        exp_t e;
        int   waits, edges, rst_seen;
        sb.push_back(model(op, a, b, cin, clr, n));
        @(negedge clock);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_clr = clr; cmd_count = CW'(n);
        cmd_valid = 1'b1;
        waits = 0;
        while (!cmd_ready && waits < 50) begin
            @(negedge clock);
            waits++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        @(posedge clock);
        edges = 1;
        rst_seen = 0;
        @(negedge clock);
        cmd_valid = 1'b0;
        while (!rsp_valid && edges < 100) begin
            if (alu_reset) rst_seen++;
            @(posedge clock);
            @(negedge clock);
            edges++;
        end
        e = sb.pop_front();
        check($sformatf("latency op%0d", op), edges, e.lat);
        check($sformatf("rsp_data op%0d", op), rsp_data, e.data);
        check($sformatf("rsp_cout op%0d", op), rsp_cout, e.cout);
        check("alu_reset_pulses", rst_seen, e.clr_used);
        check("cmd_ready_in_resp", cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            cmd_op = 2'b11; cmd_a = 8'h55; cmd_b = 8'hAA; cmd_valid = 1'b1;
            @(posedge clock);
            @(negedge clock);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, e.data);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("busy_after_hs", busy, 0);
        check("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; cmd_clr = 1'b0; cmd_count = '0;
        repeat (3) @(negedge clock);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset busy", busy, 0);
        check("reset alu_outs", {alu_a, alu_b, alu_s, alu_L, alu_En}, 0);
        check("reset rsp", {rsp_data, rsp_cout}, 0);
        check("reset alu_reset", alu_reset, 1);
        check("reset cmd_ready", cmd_ready, 1);
        reset = 1'b0;

        issue(2'b00, 8'h7F, 8'h01, 1'b0, 1'b0, 0, 0);
        issue(2'b00, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 0);
        issue(2'b11, 8'hF0, 8'h3C, 1'b0, 1'b0, 0, 0);
        issue(2'b10, 8'h10, 8'h00, 1'b0, 1'b0, 5, 0);
        issue(2'b10, 8'hFE, 8'h00, 1'b0, 1'b0, 3, 0);
        issue(2'b01, 8'hFF, 8'h00, 1'b0, 1'b1, 8, 0);
        issue(2'b01, 8'h01, 8'h00, 1'b0, 1'b1, 0, 0);
        issue(2'b10, 8'h42, 8'h00, 1'b0, 1'b1, 0, 0);
        issue(2'b00, 8'h12, 8'h34, 1'b1, 1'b1, 0, 3);

        // Abort a COUNT in the middle of RUN.
        @(negedge clock);
        cmd_op = 2'b10; cmd_a = 8'h20; cmd_count = CW'(10); cmd_clr = 1'b0; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("abort in_run busy", busy, 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort rsp_valid", rsp_valid, 0);
        check("abort busy", busy, 0);
        check("abort cmd_ready", cmd_ready, 1);
        check("abort alu_En", alu_En, 0);
        seen = 0;
        rsp_ready = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (rsp_valid || busy) seen++;
        end
        rsp_ready = 1'b0;
        check("abort no_response", seen, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic       clr;
            op  = 2'($urandom_range(0, 3));
            clr = (op == 2'b01) ? 1'b1 : 1'($urandom_range(0, 1));
            issue(op, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), clr,
                  $urandom_range(0, 15), $urandom_range(0, 2));
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
